// File: rtl/fetch_align.sv
// rtl/fetch_align.sv - instruction fetch and 16/32-bit realignment ahead of decode
module fetch_align #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_rvalid,
  input  logic        stall_l1,
  input  logic        jump_en_l1,
  input  logic [31:0] jump_addr_l1,
  input  logic        jump_en_ex,
  input  logic [31:0] jump_addr_ex,
  output logic [31:0] ins_l1,
  output logic [31:0] pc_l1,
  output logic        valid_l1
);

  localparam logic [1:0]  S_IDLE = 2'd0;
  localparam logic [1:0]  S_WAIT = 2'd1;
  localparam logic [1:0]  S_KILL = 2'd2;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic [1:0]  r_state;
  logic [31:0] r_fetch_pc;
  logic [31:0] r_req_pc;
  logic [31:0] r_wbuf;
  logic [31:0] r_wpc;
  logic        r_wbuf_v;
  logic [15:0] r_hbuf;
  logic [31:0] r_hpc;
  logic        r_hbuf_v;
  logic        r_drop_low;
  logic [31:0] r_ins;
  logic [31:0] r_pc;
  logic        r_valid;

  logic        w_redir;
  logic [31:0] w_target;
  logic        w_unused_target_bit0;
  logic        w_can_load;
  logic        w_req;
  logic        w_emit;
  logic [31:0] w_emit_ins;
  logic [31:0] w_emit_pc;
  logic        w_wbuf_clr;
  logic        w_hbuf_clr;
  logic        w_hbuf_load;
  logic        w_drop_clr;
  logic [31:0] w_wpc2;

  // A decode redirect only counts when the jal actually leaves l1; execute always wins.
  assign w_redir    = jump_en_ex || (jump_en_l1 && r_valid && !stall_l1);
  assign w_target   = jump_en_ex ? jump_addr_ex : jump_addr_l1;
  assign w_unused_target_bit0 = w_target[0];
  assign w_can_load = !r_valid || !stall_l1;
  assign w_req      = !rst && (r_state == S_IDLE) && !r_wbuf_v && !w_redir;
  assign w_wpc2     = r_wpc + 32'd2;

  assign imem_req  = w_req;
  assign imem_addr = r_fetch_pc;
  assign ins_l1    = r_ins;
  assign pc_l1     = r_pc;
  assign valid_l1  = r_valid;

  // Assembly: pick at most one action per cycle from the half/word buffers, in priority order.
  always_comb begin
    w_emit      = 1'b0;
    w_emit_ins  = NOP;
    w_emit_pc   = r_pc;
    w_wbuf_clr  = 1'b0;
    w_hbuf_clr  = 1'b0;
    w_hbuf_load = 1'b0;
    w_drop_clr  = 1'b0;
    if (w_can_load && !w_redir) begin
      if (r_hbuf_v && (r_hbuf[1:0] != 2'b11)) begin
        w_emit     = 1'b1;
        w_emit_ins = {16'h0000, r_hbuf};
        w_emit_pc  = r_hpc;
        w_hbuf_clr = 1'b1;
      end else if (r_wbuf_v && r_hbuf_v) begin
        w_emit      = 1'b1;
        w_emit_ins  = {r_wbuf[15:0], r_hbuf};
        w_emit_pc   = r_hpc;
        w_hbuf_load = 1'b1;
        w_wbuf_clr  = 1'b1;
      end else if (r_wbuf_v && r_drop_low) begin
        w_hbuf_load = 1'b1;
        w_drop_clr  = 1'b1;
        w_wbuf_clr  = 1'b1;
      end else if (r_wbuf_v && (r_wbuf[1:0] != 2'b11)) begin
        w_emit      = 1'b1;
        w_emit_ins  = {16'h0000, r_wbuf[15:0]};
        w_emit_pc   = r_wpc;
        w_hbuf_load = 1'b1;
        w_wbuf_clr  = 1'b1;
      end else if (r_wbuf_v) begin
        w_emit     = 1'b1;
        w_emit_ins = r_wbuf;
        w_emit_pc  = r_wpc;
        w_wbuf_clr = 1'b1;
      end
    end
  end

  // Request FSM: one outstanding fetch; a redirect during a fetch kills the returning word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_req) r_state <= S_WAIT;
        S_WAIT: begin
          if (imem_rvalid)  r_state <= S_IDLE;
          else if (w_redir) r_state <= S_KILL;
        end
        S_KILL:  if (imem_rvalid) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Fetch pointer: restart on redirect, otherwise advance one word per issued request.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= {RESET_PC[31:2], 2'b00};
      r_req_pc   <= {RESET_PC[31:2], 2'b00};
    end else if (w_redir) begin
      r_fetch_pc <= {w_target[31:2], 2'b00};
    end else if (w_req) begin
      r_req_pc   <= r_fetch_pc;
      r_fetch_pc <= r_fetch_pc + 32'd4;
    end
  end

  // Word buffer: filled by a live response, drained by assembly, flushed by redirects.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wbuf_v <= 1'b0;
      r_wbuf   <= 32'h0;
      r_wpc    <= 32'h0;
    end else if (w_redir) begin
      r_wbuf_v <= 1'b0;
    end else if ((r_state == S_WAIT) && imem_rvalid) begin
      r_wbuf_v <= 1'b1;
      r_wbuf   <= imem_rdata;
      r_wpc    <= r_req_pc;
    end else if (w_wbuf_clr) begin
      r_wbuf_v <= 1'b0;
    end
  end

  // Half buffer: carries the upper half of a word into the next assembly step.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hbuf_v <= 1'b0;
      r_hbuf   <= 16'h0;
      r_hpc    <= 32'h0;
    end else if (w_redir) begin
      r_hbuf_v <= 1'b0;
    end else if (w_hbuf_load) begin
      r_hbuf_v <= 1'b1;
      r_hbuf   <= r_wbuf[31:16];
      r_hpc    <= w_wpc2;
    end else if (w_hbuf_clr) begin
      r_hbuf_v <= 1'b0;
    end
  end

  // Drop-low flag: a target at pc%4==2 discards the low half of its first word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop_low <= RESET_PC[1];
    end else if (w_redir) begin
      r_drop_low <= w_target[1];
    end else if (w_drop_clr) begin
      r_drop_low <= 1'b0;
    end
  end

  // l1 register: load on emit, bubble to NOP when consumed, hold under stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_ins   <= NOP;
      r_pc    <= RESET_PC;
    end else if (w_redir) begin
      r_valid <= 1'b0;
      r_ins   <= NOP;
    end else if (w_emit) begin
      r_valid <= 1'b1;
      r_ins   <= w_emit_ins;
      r_pc    <= w_emit_pc;
    end else if (!stall_l1) begin
      r_valid <= 1'b0;
      r_ins   <= NOP;
    end
  end

endmodule

// File: tb/tb_fetch_align.sv
// tb/tb_fetch_align.sv - scoreboard bench for fetch_align
module tb_fetch_align;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_rvalid = 1'b0;
  logic        stall_l1 = 1'b0;
  logic        jump_en_l1 = 1'b0;
  logic [31:0] jump_addr_l1 = 32'h0;
  logic        jump_en_ex = 1'b0;
  logic [31:0] jump_addr_ex = 32'h0;
  logic [31:0] ins_l1;
  logic [31:0] pc_l1;
  logic        valid_l1;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:255];
  logic [31:0] exp_pc_q[$];
  logic [31:0] exp_ins_q[$];
  logic [31:0] req_log[$];
  int          lat = 1;
  bit          m_busy = 1'b0;
  int          m_cnt = 0;
  logic [31:0] m_data = 32'h0;

  fetch_align #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_rvalid(imem_rvalid),
    .stall_l1(stall_l1),
    .jump_en_l1(jump_en_l1), .jump_addr_l1(jump_addr_l1),
    .jump_en_ex(jump_en_ex), .jump_addr_ex(jump_addr_ex),
    .ins_l1(ins_l1), .pc_l1(pc_l1), .valid_l1(valid_l1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // memory with programmable latency; requests are taken on the edge after this negedge
  always @(negedge clk) begin
    imem_rvalid = 1'b0;
    if (m_busy) begin
      m_cnt--;
      if (m_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = m_data;
        m_busy      = 1'b0;
      end
    end
    if (imem_req && !rst) begin
      m_busy = 1'b1;
      m_cnt  = lat;
      m_data = mem[imem_addr[9:2]];
      req_log.push_back(imem_addr);
    end
  end

  // scoreboard: compare each instruction as it leaves l1
  always @(negedge clk) begin
    if (!rst) begin
      if (!valid_l1) begin
        chk("idle_nop", ins_l1, NOP);
      end else if (!stall_l1 && !jump_en_ex && exp_pc_q.size() > 0) begin
        chk("sb_pc", pc_l1, exp_pc_q.pop_front());
        chk("sb_ins", ins_l1, exp_ins_q.pop_front());
      end
    end
  end

  task automatic fill();
    for (int i = 0; i < 256; i++) mem[i] = NOP;
  endtask

  task automatic expect_ins(input logic [31:0] pc, input logic [31:0] ins);
    exp_pc_q.push_back(pc);
    exp_ins_q.push_back(ins);
  endtask

  task automatic do_reset(input int l);
    @(posedge clk); #1;
    rst = 1'b1; stall_l1 = 1'b0; jump_en_l1 = 1'b0; jump_en_ex = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", {31'h0, valid_l1}, 32'h0);
    chk("rst_ins", ins_l1, NOP);
    chk("rst_pc", pc_l1, 32'h0);
    repeat (6) @(posedge clk);
    #1;
    lat = l;
    req_log.delete();
    exp_pc_q.delete();
    exp_ins_q.delete();
    rst = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!valid_l1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk(tag, {31'h0, valid_l1}, 32'h1);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_pc_q.size() > 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk(tag, 32'(exp_pc_q.size()), 32'h0);
  endtask

  function automatic logic [31:0] req_at(input int i);
    return (req_log.size() > i) ? req_log[i] : 32'hDEAD_BEEF;
  endfunction

  initial begin
    int  rc0;
    bit  found;

    // two aligned 32-bit instructions
    fill();
    mem[0] = 32'h0000_0013;
    mem[1] = 32'h0010_0093;
    do_reset(1);
    expect_ins(32'h0, 32'h0000_0013);
    expect_ins(32'h4, 32'h0010_0093);
    drain("t1_drain");

    // two C halves in one word
    fill();
    mem[0] = 32'h4505_0001;
    do_reset(1);
    expect_ins(32'h0, 32'h0000_0001);
    expect_ins(32'h2, 32'h0000_4505);
    drain("t2_drain");
    chk("t2_next_addr", req_at(1), 32'h4);

    // 32-bit instruction straddling a word boundary
    fill();
    mem[0] = 32'h0513_0001;
    mem[1] = 32'h0001_0010;
    do_reset(1);
    expect_ins(32'h0, 32'h0000_0001);
    expect_ins(32'h2, 32'h0010_0513);
    expect_ins(32'h6, 32'h0000_0001);
    drain("t3_drain");

    // execute redirect while a slow fetch is in flight
    fill();
    mem[64] = 32'h4505_0001;
    do_reset(3);
    @(posedge clk); #1;
    jump_en_ex = 1'b1; jump_addr_ex = 32'h0000_0102;
    req_log.delete();
    expect_ins(32'h102, 32'h0000_4505);
    expect_ins(32'h104, NOP);
    @(posedge clk); #1;
    jump_en_ex = 1'b0;
    drain("t4_drain");
    chk("t4_first_addr", req_at(0), 32'h100);

    // three-cycle stall on a live instruction
    fill();
    mem[1] = 32'h0010_0093;
    mem[2] = 32'h0020_0113;
    mem[3] = 32'h0030_0193;
    do_reset(1);
    expect_ins(32'h0, NOP);
    expect_ins(32'h4, 32'h0010_0093);
    expect_ins(32'h8, 32'h0020_0113);
    expect_ins(32'hC, 32'h0030_0193);
    wait_valid("t5_valid");
    stall_l1 = 1'b1;
    rc0 = req_log.size();
    repeat (3) begin
      @(negedge clk);
      chk("t5_hold_pc", pc_l1, 32'h0);
      chk("t5_hold_ins", ins_l1, NOP);
      chk("t5_hold_valid", {31'h0, valid_l1}, 32'h1);
    end
    @(posedge clk); #1;
    stall_l1 = 1'b0;
    chk("t5_extra_req", {31'h0, (req_log.size() - rc0) <= 1}, 32'h1);
    drain("t5_drain");

    // both redirects together, execute target wins (bit0 ignored)
    fill();
    mem[64]  = 32'h00A0_0093;
    mem[128] = 32'h00B0_0113;
    do_reset(1);
    wait_valid("t6_valid");
    jump_en_l1 = 1'b1; jump_addr_l1 = 32'h0000_0200;
    jump_en_ex = 1'b1; jump_addr_ex = 32'h0000_0101;
    req_log.delete();
    expect_ins(32'h100, 32'h00A0_0093);
    expect_ins(32'h104, NOP);
    @(posedge clk); #1;
    jump_en_l1 = 1'b0; jump_en_ex = 1'b0;
    drain("t6_drain");
    chk("t6_first_addr", req_at(0), 32'h100);

    // decode redirect held off by stall
    fill();
    mem[128] = 32'h00B0_0113;
    do_reset(1);
    expect_ins(32'h0, NOP);
    wait_valid("t7_valid");
    stall_l1 = 1'b1;
    jump_en_l1 = 1'b1; jump_addr_l1 = 32'h0000_0200;
    repeat (2) begin
      @(negedge clk);
      chk("t7_hold_pc", pc_l1, 32'h0);
      chk("t7_hold_valid", {31'h0, valid_l1}, 32'h1);
    end
    found = 1'b0;
    foreach (req_log[i]) if (req_log[i] == 32'h200) found = 1'b1;
    chk("t7_no_early_redir", {31'h0, found}, 32'h0);
    @(posedge clk); #1;
    stall_l1 = 1'b0;
    req_log.delete();
    expect_ins(32'h200, 32'h00B0_0113);
    expect_ins(32'h204, NOP);
    @(posedge clk); #1;
    jump_en_l1 = 1'b0;
    drain("t7_drain");
    chk("t7_first_addr", req_at(0), 32'h200);

    // redirect to the top halfword, instruction wraps through address 0
    fill();
    mem[255] = 32'h0093_0000;
    mem[0]   = 32'h0001_00A0;
    do_reset(1);
    jump_en_ex = 1'b1; jump_addr_ex = 32'hFFFF_FFFE;
    expect_ins(32'hFFFF_FFFE, 32'h00A0_0093);
    expect_ins(32'h0000_0002, 32'h0000_0001);
    @(posedge clk); #1;
    jump_en_ex = 1'b0;
    drain("t8_drain");
    chk("t8_addr0", req_at(0), 32'hFFFF_FFFC);
    chk("t8_addr1", req_at(1), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
